// File: rtl/dmem_wb_bridge_pkg.sv
// Shared constants, FSM encoding and helpers for the MEM-stage Wishbone bridge.
package dmem_wb_bridge_pkg;

    localparam int unsigned RegBusW              = 32;
    localparam int unsigned WbSelW               = 4;
    localparam int unsigned StallW               = 6;
    localparam int unsigned DefaultTimeoutCycles = 255;

    localparam logic [RegBusW-1:0] ZeroWord    = '0;
    localparam logic               ChipEnable  = 1'b1;
    localparam logic               WriteEnable = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StHold = 2'b10
    } state_e;

    // Counter width able to hold 0 .. cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/dmem_wb_bridge_if.sv
// Wishbone B4 classic data bus between the bridge (master) and a slave.
interface dmem_wb_bridge_if;
    import dmem_wb_bridge_pkg::*;

    logic [RegBusW-1:0] wb_adr_o;
    logic [RegBusW-1:0] wb_dat_o;
    logic [WbSelW-1:0]  wb_sel_o;
    logic               wb_we_o;
    logic               wb_stb_o;
    logic               wb_cyc_o;
    logic [RegBusW-1:0] wb_dat_i;
    logic               wb_ack_i;
    logic               wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module wb_timeout_counter
    import dmem_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned     CntW    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign tc_o = (r_cnt == TermCnt);

endmodule

// File: rtl/dmem_wb_bridge.sv
// Converts single-cycle MEM-stage requests into Wishbone classic cycles, stalling until done
// and holding load data while the MEM stage stays frozen.
module dmem_wb_bridge
    import dmem_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
    parameter int unsigned MEM_STALL_BIT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [StallW-1:0]  stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [RegBusW-1:0] cpu_addr_i,
    input  logic [WbSelW-1:0]  cpu_sel_i,
    input  logic [RegBusW-1:0] cpu_data_i,
    output logic [RegBusW-1:0] cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    dmem_wb_bridge_if.master   wb
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [RegBusW-1:0] r_wb_adr;
    logic [RegBusW-1:0] r_wb_dat;
    logic [WbSelW-1:0]  r_wb_sel;
    logic               r_wb_we;
    logic               r_wb_cyc;
    logic [RegBusW-1:0] r_hold;
    logic               r_bus_err;

    logic w_mem_stall;
    logic w_busy;
    logic w_start;
    logic w_ack;
    logic w_err;
    logic w_tc;
    logic w_tmo;
    logic w_done;
    logic w_rd_ack;

    assign w_mem_stall = stall_i[MEM_STALL_BIT];
    assign w_busy      = (r_state == StBusy);
    assign w_start     = (r_state == StIdle) && (cpu_ce_i == ChipEnable) && !flush_i;
    // Ack wins over a simultaneous err; timeout only fires with no termination at all.
    assign w_ack       = w_busy && wb.wb_ack_i;
    assign w_err       = w_busy && !wb.wb_ack_i && wb.wb_err_i;
    assign w_tmo       = w_busy && !wb.wb_ack_i && !wb.wb_err_i && w_tc;
    assign w_done      = w_ack || w_err || w_tmo;
    assign w_rd_ack    = w_ack && (r_wb_we != WriteEnable);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_start),
        .en_i  (w_busy && !w_done && !flush_i),
        .tc_o  (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stallreq_o  = 1'b0;
        cpu_data_o  = ZeroWord;
        unique case (r_state)
            StIdle: begin
                stallreq_o = w_start;
                if (w_start) begin
                    w_state_nxt = StBusy;
                end
            end
            StBusy: begin
                if (flush_i) begin
                    w_state_nxt = StIdle;
                end else begin
                    stallreq_o = !w_done;
                    if (w_done) begin
                        w_state_nxt = w_mem_stall ? StHold : StIdle;
                    end
                    if (w_rd_ack) begin
                        cpu_data_o = wb.wb_dat_i;
                    end
                end
            end
            StHold: begin
                cpu_data_o = r_hold;
                if (!w_mem_stall || flush_i) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        // Combinational request must not leak out while the core is held in reset.
        if (!rst_n) begin
            stallreq_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_adr  <= ZeroWord;
            r_wb_dat  <= ZeroWord;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_cyc  <= 1'b0;
            r_hold    <= ZeroWord;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            if (w_start) begin
                r_wb_adr <= cpu_addr_i;
                r_wb_dat <= cpu_data_i;
                r_wb_sel <= cpu_sel_i;
                r_wb_we  <= cpu_we_i;
                r_wb_cyc <= 1'b1;
            end else if (w_busy && (flush_i || w_done)) begin
                r_wb_adr  <= ZeroWord;
                r_wb_dat  <= ZeroWord;
                r_wb_sel  <= '0;
                r_wb_we   <= 1'b0;
                r_wb_cyc  <= 1'b0;
                r_hold    <= (!flush_i && w_rd_ack) ? wb.wb_dat_i : ZeroWord;
                r_bus_err <= !flush_i && (w_err || w_tmo);
            end
        end
    end

    assign wb.wb_adr_o = r_wb_adr;
    assign wb.wb_dat_o = r_wb_dat;
    assign wb.wb_sel_o = r_wb_sel;
    assign wb.wb_we_o  = r_wb_we;
    assign wb.wb_cyc_o = r_wb_cyc;
    assign wb.wb_stb_o = r_wb_cyc;
    assign bus_err_o   = r_bus_err;

endmodule
